// File: rtl/writeback_buffer.sv
// Multi-lane writeback buffer: per-lane load extraction, in-order circular queue,
// WPORTS-wide regfile drain with HI/LO serialisation and youngest-match forwarding.
module writeback_buffer #(
   parameter int LANES  = 2,
   parameter int WPORTS = 1,
   parameter int DEPTH  = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [LANES-1:0]        in_valid,
   output logic                    in_ready,
   input  logic [LANES-1:0]        in_regwrite,
   input  logic [5*LANES-1:0]      in_writereg,
   input  logic [LANES-1:0]        in_memread,
   input  logic [3*LANES-1:0]      in_mem_type,
   input  logic [32*LANES-1:0]     in_aluout,
   input  logic [32*LANES-1:0]     in_rd,
   input  logic [32*LANES-1:0]     in_pcplus4,
   input  logic [LANES-1:0]        in_hi_wen,
   input  logic [LANES-1:0]        in_lo_wen,
   input  logic [32*LANES-1:0]     in_hi,
   input  logic [32*LANES-1:0]     in_lo,
   output logic [WPORTS-1:0]       rf_wen,
   output logic [5*WPORTS-1:0]     rf_wid,
   output logic [32*WPORTS-1:0]    rf_wdata,
   output logic                    hi_wen,
   output logic                    lo_wen,
   output logic [31:0]             hi_wdata,
   output logic [31:0]             lo_wdata,
   input  logic [4:0]              lookup_id,
   output logic                    lookup_hit,
   output logic [31:0]             lookup_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic [31:0]             debug_pc,
   output logic                    debug_wen
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_dbg_wen;
   logic [31:0]   r_dbg_pc;

   logic          r_regwrite [DEPTH];
   logic [4:0]    r_wreg     [DEPTH];
   logic [31:0]   r_result   [DEPTH];
   logic          r_hiw      [DEPTH];
   logic          r_low      [DEPTH];
   logic [31:0]   r_hi       [DEPTH];
   logic [31:0]   r_lo       [DEPTH];
   logic [31:0]   r_pc4      [DEPTH];

   logic [CW-1:0] w_free;
   logic          w_accept;
   logic [CW-1:0] w_push_cnt;
   logic [PW-1:0] w_lane_ptr [LANES];
   logic [CW-1:0] w_pop;
   logic [WPORTS-1:0] w_in_win;
   logic [PW-1:0] w_dptr [WPORTS];
   logic [PW-1:0] w_last_ptr;
   logic [PW-1:0] w_hl_ptr;
   logic          w_hl_any;

   function automatic logic [31:0] f_ext(input logic [2:0] t, input logic [1:0] a,
                                         input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = a[1] ? rd[31:16] : rd[15:0];
      case (t)
         3'd1:    f_ext = {{16{h[15]}}, h};
         3'd2:    f_ext = {16'b0, h};
         3'd3:    f_ext = {{24{b[7]}}, b};
         3'd4:    f_ext = {24'b0, b};
         default: f_ext = rd;
      endcase
   endfunction

   // Credit only the registered occupancy so in_ready never depends on in_valid.
   assign w_free   = CW'(DEPTH) - r_count;
   assign in_ready = (w_free >= CW'(LANES));
   assign w_accept = in_ready && (|in_valid);
   assign count    = r_count;
   assign debug_pc = r_dbg_pc;
   assign debug_wen = r_dbg_wen;

   always_comb begin
      w_push_cnt = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         w_lane_ptr[l] = r_tail + w_push_cnt[PW-1:0];
         if (in_valid[l]) w_push_cnt = w_push_cnt + CW'(1);
      end
      if (!w_accept) w_push_cnt = '0;
   end

   always_ff @(posedge clk) begin
      for (int unsigned l = 0; l < LANES; l++) begin
         if (w_accept && in_valid[l]) begin
            r_regwrite[w_lane_ptr[l]] <= in_regwrite[l];
            r_wreg[w_lane_ptr[l]]     <= in_writereg[5*l +: 5];
            r_result[w_lane_ptr[l]]   <= in_memread[l]
               ? f_ext(in_mem_type[3*l +: 3], in_aluout[32*l +: 2], in_rd[32*l +: 32])
               : in_aluout[32*l +: 32];
            r_hiw[w_lane_ptr[l]]      <= in_hi_wen[l];
            r_low[w_lane_ptr[l]]      <= in_lo_wen[l];
            r_hi[w_lane_ptr[l]]       <= in_hi[32*l +: 32];
            r_lo[w_lane_ptr[l]]       <= in_lo[32*l +: 32];
            r_pc4[w_lane_ptr[l]]      <= in_pcplus4[32*l +: 32];
         end
      end
   end

   // Drain window: stops at the occupancy limit or at a second HI/LO writer.
   always_comb begin
      logic w_stop;
      logic w_hl;
      w_stop     = 1'b0;
      w_pop      = '0;
      w_in_win   = '0;
      w_hl_any   = 1'b0;
      w_hl_ptr   = r_head;
      w_last_ptr = r_head;
      for (int unsigned i = 0; i < WPORTS; i++) begin
         w_dptr[i] = r_head + PW'(i);
         w_hl      = r_hiw[w_dptr[i]] || r_low[w_dptr[i]];
         if (!w_stop && (CW'(i) < r_count) && !(w_hl && w_hl_any)) begin
            w_in_win[i] = 1'b1;
            w_pop       = w_pop + CW'(1);
            w_last_ptr  = w_dptr[i];
            if (w_hl) begin
               w_hl_any = 1'b1;
               w_hl_ptr = w_dptr[i];
            end
         end else begin
            w_stop = 1'b1;
         end
      end
   end

   always_comb begin
      rf_wen   = '0;
      rf_wid   = '0;
      rf_wdata = '0;
      for (int unsigned i = 0; i < WPORTS; i++) begin
         rf_wen[i] = w_in_win[i] && r_regwrite[w_dptr[i]] && (r_wreg[w_dptr[i]] != 5'd0);
         for (int unsigned j = i + 1; j < WPORTS; j++) begin
            if (w_in_win[j] && r_regwrite[w_dptr[j]] && (r_wreg[w_dptr[j]] == r_wreg[w_dptr[i]]))
               rf_wen[i] = 1'b0;
         end
         if (rf_wen[i]) begin
            rf_wid[5*i +: 5]    = r_wreg[w_dptr[i]];
            rf_wdata[32*i +: 32] = r_result[w_dptr[i]];
         end
      end
      hi_wen   = w_hl_any && r_hiw[w_hl_ptr];
      lo_wen   = w_hl_any && r_low[w_hl_ptr];
      hi_wdata = hi_wen ? r_hi[w_hl_ptr] : '0;
      lo_wdata = lo_wen ? r_lo[w_hl_ptr] : '0;
   end

   // Scan oldest to youngest so the last match is the youngest writer.
   always_comb begin
      logic [PW-1:0] w_idx;
      lookup_hit  = 1'b0;
      lookup_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PW'(k);
         if ((CW'(k) < r_count) && r_regwrite[w_idx] && (r_wreg[w_idx] == lookup_id)
             && (lookup_id != 5'd0)) begin
            lookup_hit  = 1'b1;
            lookup_data = r_result[w_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_dbg_wen <= 1'b0;
         r_dbg_pc  <= '0;
      end else begin
         r_head    <= r_head + w_pop[PW-1:0];
         r_tail    <= r_tail + w_push_cnt[PW-1:0];
         r_count   <= r_count + w_push_cnt - w_pop;
         r_dbg_wen <= (w_pop != '0);
         if (w_pop != '0) r_dbg_pc <= r_pc4[w_last_ptr] - 32'd4;
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// Scoreboard bench for writeback_buffer (LANES=2, WPORTS=2, DEPTH=8): the stimulus
// pushes accepted entries into a program-order queue; a negedge monitor checks drains.
module tb_writeback_buffer;

   logic         clk = 1'b0;
   logic         resetn;
   logic [1:0]   in_valid;
   logic         in_ready;
   logic [1:0]   in_regwrite;
   logic [9:0]   in_writereg;
   logic [1:0]   in_memread;
   logic [5:0]   in_mem_type;
   logic [63:0]  in_aluout, in_rd, in_pcplus4, in_hi, in_lo;
   logic [1:0]   in_hi_wen, in_lo_wen;
   logic [1:0]   rf_wen;
   logic [9:0]   rf_wid;
   logic [63:0]  rf_wdata;
   logic         hi_wen, lo_wen;
   logic [31:0]  hi_wdata, lo_wdata;
   logic [4:0]   lookup_id;
   logic         lookup_hit;
   logic [31:0]  lookup_data;
   logic [3:0]   count;
   logic [31:0]  debug_pc;
   logic         debug_wen;

   writeback_buffer #(.LANES(2), .WPORTS(2), .DEPTH(8)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_regwrite(in_regwrite), .in_writereg(in_writereg), .in_memread(in_memread),
      .in_mem_type(in_mem_type), .in_aluout(in_aluout), .in_rd(in_rd),
      .in_pcplus4(in_pcplus4), .in_hi_wen(in_hi_wen), .in_lo_wen(in_lo_wen),
      .in_hi(in_hi), .in_lo(in_lo), .rf_wen(rf_wen), .rf_wid(rf_wid),
      .rf_wdata(rf_wdata), .hi_wen(hi_wen), .lo_wen(lo_wen), .hi_wdata(hi_wdata),
      .lo_wdata(lo_wdata), .lookup_id(lookup_id), .lookup_hit(lookup_hit),
      .lookup_data(lookup_data), .count(count), .debug_pc(debug_pc), .debug_wen(debug_wen)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        rw;
      bit [4:0]  wr;
      bit [31:0] res;
      bit        hiw;
      bit        low;
      bit [31:0] hi;
      bit [31:0] lo;
      bit [31:0] pc4;
   } ent_t;

   ent_t      mq[$];
   ent_t      g_e[2];
   bit        g_v[2];
   bit        exp_ready = 1'b1;
   bit        exp_dbg_wen = 1'b0;
   bit [31:0] exp_dbg_pc = '0;
   bit        mon_en = 1'b0;
   int        n_chk = 0;
   int        n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   function automatic bit [31:0] m_ext(input bit mr, input bit [2:0] mt,
                                       input bit [31:0] a, input bit [31:0] rd);
      bit [31:0] b, h;
      b = (rd >> (8 * a[1:0])) & 32'hFF;
      h = (rd >> (16 * a[1])) & 32'hFFFF;
      if (!mr) return a;
      case (mt)
         3'd1:    return (h ^ 32'h8000) - 32'h8000;
         3'd2:    return h;
         3'd3:    return (b ^ 32'h80) - 32'h80;
         3'd4:    return b;
         default: return rd;
      endcase
   endfunction

   task automatic clear_inputs();
      in_valid = '0; in_regwrite = '0; in_writereg = '0; in_memread = '0;
      in_mem_type = '0; in_aluout = '0; in_rd = '0; in_pcplus4 = '0;
      in_hi_wen = '0; in_lo_wen = '0; in_hi = '0; in_lo = '0;
      g_v[0] = 1'b0; g_v[1] = 1'b0;
   endtask

   task automatic set_lane(input int l, input bit rw, input bit [4:0] wr, input bit mr,
                           input bit [2:0] mt, input bit [31:0] alu, input bit [31:0] rd,
                           input bit [31:0] pc4, input bit hiw, input bit low,
                           input bit [31:0] hi, input bit [31:0] lo);
      in_valid[l] = 1'b1;         in_regwrite[l] = rw;
      in_writereg[5*l +: 5] = wr; in_memread[l] = mr;
      in_mem_type[3*l +: 3] = mt; in_aluout[32*l +: 32] = alu;
      in_rd[32*l +: 32] = rd;     in_pcplus4[32*l +: 32] = pc4;
      in_hi_wen[l] = hiw;         in_lo_wen[l] = low;
      in_hi[32*l +: 32] = hi;     in_lo[32*l +: 32] = lo;
      g_v[l] = 1'b1;
      g_e[l] = '{rw: rw, wr: wr, res: m_ext(mr, mt, alu, rd), hiw: hiw, low: low,
                 hi: hi, lo: lo, pc4: pc4};
   endtask

   task automatic rand_lane(input int l, input bit force_hl);
      bit hw, lw;
      hw = force_hl || ($urandom_range(0, 5) == 0);
      lw = ($urandom_range(0, 5) == 0);
      set_lane(l, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
               $urandom(), hw, lw, $urandom(), $urandom());
   endtask

   // Group driven now is captured at the next edge when the model says there is room.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (exp_ready) begin
         for (int l = 0; l < 2; l++) if (g_v[l]) mq.push_back(g_e[l]);
      end
      clear_inputs();
   endtask

   int        m_size, m_take, m_hsel;
   bit        m_seen, m_hl, m_ew, m_hit, m_eh, m_el;
   bit [31:0] m_data;

   always @(negedge clk) begin
      if (resetn && mon_en) begin
         m_size    = mq.size();
         exp_ready = (8 - m_size) >= 2;
         chk("in_ready", in_ready, exp_ready);
         chk("count", count, m_size);
         m_hit = 1'b0; m_data = '0;
         foreach (mq[k]) begin
            if (mq[k].rw && mq[k].wr == lookup_id && lookup_id != 0) begin
               m_hit = 1'b1; m_data = mq[k].res;
            end
         end
         chk("lookup_hit", lookup_hit, m_hit);
         if (m_hit) chk("lookup_data", lookup_data, m_data);
         chk("debug_wen", debug_wen, exp_dbg_wen);
         if (exp_dbg_wen) chk("debug_pc", debug_pc, exp_dbg_pc);
         m_take = 0; m_seen = 1'b0; m_hsel = 0;
         for (int i = 0; i < 2 && i < m_size; i++) begin
            m_hl = mq[i].hiw || mq[i].low;
            if (m_hl && m_seen) break;
            if (m_hl) begin m_seen = 1'b1; m_hsel = i; end
            m_take++;
         end
         for (int i = 0; i < 2; i++) begin
            m_ew = (i < m_take) && mq[i].rw && (mq[i].wr != 0);
            for (int j = i + 1; j < m_take; j++)
               if (m_ew && mq[j].rw && mq[j].wr == mq[i].wr) m_ew = 1'b0;
            chk("rf_wen", rf_wen[i], m_ew);
            if (m_ew) begin
               chk("rf_wid", rf_wid[5*i +: 5], mq[i].wr);
               chk("rf_wdata", rf_wdata[32*i +: 32], mq[i].res);
            end
         end
         m_eh = m_seen && mq[m_hsel].hiw;
         m_el = m_seen && mq[m_hsel].low;
         chk("hi_wen", hi_wen, m_eh);
         chk("lo_wen", lo_wen, m_el);
         if (m_eh) chk("hi_wdata", hi_wdata, mq[m_hsel].hi);
         if (m_el) chk("lo_wdata", lo_wdata, mq[m_hsel].lo);
         exp_dbg_wen = (m_take > 0);
         if (m_take > 0) exp_dbg_pc = mq[m_take-1].pc4 - 32'd4;
         repeat (m_take) void'(mq.pop_front());
      end
   end

   initial begin
      resetn = 1'b0;
      lookup_id = '0;
      clear_inputs();
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", count, 0);
      chk("rst_rf_wen", rf_wen, 0);
      chk("rst_hilo_wen", {hi_wen, lo_wen}, 0);
      chk("rst_lookup_hit", lookup_hit, 0);
      chk("rst_debug", {debug_wen, debug_pc}, 0);
      @(negedge clk); #1;
      resetn = 1'b1;
      mon_en = 1'b1;

      // LB from byte 3 of 0x80AABBCC -> 0xFFFFFF80 in r5
      set_lane(0, 1, 5'd5, 1, 3'd3, 32'h1003, 32'h80AA_BBCC, 32'h0000_0104, 0, 0, 0, 0);
      cycle();
      repeat (3) cycle();
      set_lane(0, 1, 5'd3, 0, 0, 32'd1, 0, 32'h200, 0, 0, 0, 0);
      set_lane(1, 1, 5'd4, 0, 0, 32'd2, 0, 32'h204, 0, 0, 0, 0);
      cycle();
      repeat (2) cycle();
      set_lane(0, 1, 5'd7, 0, 0, 32'h11, 0, 32'h300, 0, 0, 0, 0);
      set_lane(1, 1, 5'd7, 0, 0, 32'h22, 0, 32'h304, 0, 0, 0, 0);
      cycle();
      repeat (2) cycle();
      set_lane(0, 0, 5'd0, 0, 0, 0, 0, 32'h400, 1, 1, 32'h1, 32'h2);
      set_lane(1, 0, 5'd0, 0, 0, 0, 0, 32'h404, 0, 1, 0, 32'h5);
      cycle();
      repeat (3) cycle();

      // Every entry writes HI so the drain is one per cycle and the buffer fills.
      for (int c = 0; c < 14; c++) begin
         rand_lane(0, 1); rand_lane(1, 1);
         lookup_id = 5'($urandom_range(0, 7));
         cycle();
      end
      repeat (10) cycle();

      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) != 0) rand_lane(0, 0);
         if ($urandom_range(0, 2) != 0) rand_lane(1, 0);
         lookup_id = 5'($urandom_range(0, 7));
         cycle();
      end
      repeat (10) cycle();

      lookup_id = 5'd9;
      set_lane(0, 1, 5'd9, 0, 0, 32'hA, 0, 32'h500, 0, 0, 0, 0);
      set_lane(1, 1, 5'd9, 0, 0, 32'hB, 0, 32'h504, 0, 0, 0, 0);
      cycle();
      chk("fwd_hit_r9", lookup_hit, 1);
      chk("fwd_data_r9", lookup_data, 32'hB);
      chk("dup_rf_wen", rf_wen, 2'b10);
      chk("dup_rf_wdata", rf_wdata[63:32], 32'hB);
      #1;
      resetn = 1'b0;
      #1;
      chk("midrst_rf_wen", rf_wen, 0);
      chk("midrst_hilo_wen", {hi_wen, lo_wen}, 0);
      chk("midrst_count", count, 0);
      chk("midrst_lookup_hit", lookup_hit, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_debug_wen", debug_wen, 0);
      mq.delete();
      exp_dbg_wen = 1'b0;
      exp_ready = 1'b1;
      @(negedge clk); #1;
      resetn = 1'b1;

      for (int c = 0; c < 40; c++) begin
         if ($urandom_range(0, 1) != 0) rand_lane(0, 0);
         if ($urandom_range(0, 1) != 0) rand_lane(1, 0);
         lookup_id = 5'($urandom_range(0, 7));
         cycle();
      end
      repeat (12) cycle();
      chk("final_count", count, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Parametrised multi-lane successor to the single-lane writeback stage.
- Accepts up to LANES memory-stage results per cycle and performs load-data extraction (byte/half select, sign/zero extension) per lane.
- Queues results in program order in a DEPTH-entry circular buffer and drains up to WPORTS register-file writes per cycle, plus HI/LO writes.
- Provides a youngest-match forwarding lookup into the buffer. Sits between the memory-stage pipeline register and the regfile/hilo units.

Parameters:
- LANES, 2, results presented per cycle; lane 0 is oldest.
- WPORTS, 1, regfile write ports drained per cycle (1..LANES).
- DEPTH, 8, buffer entries; power of two, DEPTH >= 2*LANES.

Ports:
- clk  in  1  clock; single clock domain.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  LANES  lane carries a committing instruction.
- in_ready  out  1  buffer can accept a full group this cycle.
- in_regwrite  in  LANES  lane writes a GPR.
- in_writereg  in  5*LANES  destination GPR.
- in_memread  in  LANES  result comes from load data.
- in_mem_type  in  3*LANES  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; other codes are treated as LW.
- in_aluout  in  32*LANES  ALU result / load address.
- in_rd  in  32*LANES  raw load word.
- in_pcplus4  in  32*LANES  PC+4 of the instruction.
- in_hi_wen, in_lo_wen  in  LANES each  HI / LO write enables.
- in_hi, in_lo  in  32*LANES each  HI / LO data.
- rf_wen  out  WPORTS  regfile write enable.
- rf_wid  out  5*WPORTS  regfile write index.
- rf_wdata  out  32*WPORTS  regfile write data.
- hi_wen, lo_wen  out  1 each  HI / LO write enables.
- hi_wdata, lo_wdata  out  32 each  HI / LO write data.
- lookup_id  in  5  register index to forward.
- lookup_hit  out  1  a buffered entry writes lookup_id.
- lookup_data  out  32  result of the youngest such entry.
- count  out  $clog2(DEPTH)+1  occupancy.
- debug_pc  out  32  PC of the last entry drained.
- debug_wen  out  1  debug_pc updated this cycle.

Behaviour:
- Reset (async, resetn=0):
  - Head, tail and count = 0; all entries invalid.
  - All outputs 0; in_ready = 1.
  - Reset mid-drain discards every entry; no partial write may occur after resetn falls.
- Enqueue:
  - in_ready = (DEPTH - count) >= LANES, computed from registered count only. Same-cycle pops are not credited, so there is no combinational path from in_valid to in_ready.
  - On in_valid != 0 && in_ready, valid lanes are compacted in lane order into consecutive entries at tail. Invalid lanes consume no entry.
  - in_valid presented while in_ready=0 is ignored (producer must hold).
- Result computation at enqueue:
  - result = memread ? ext(rd) : aluout.
  - LB/LBU: select byte aluout[1:0] (00 = bits 7:0).
  - LH/LHU: select half aluout[1] (0 = bits 15:0).
  - Sign-extend LB/LH, zero-extend LBU/LHU. Misalignment is not checked.
- Drain (combinational from head entries; pointers advance at clock edge):
  - Up to WPORTS oldest entries are presented per cycle; port i carries head+i.
  - Minimum latency enqueue->write = 1 cycle.
  - rf_wen[i] = entry.regwrite && writereg != 0. Writes to $0 pop without writing.
  - If two drained entries target the same writereg, the older entry's rf_wen is forced to 0.
  - At most one HI/LO-writing entry drains per cycle. A second such entry in the window ends the drain window before it.
  - Within a cycle, HI/LO data is taken from the single HI/LO entry drained.
- Count: next count = count + pushed - popped. Wrap-around at DEPTH is modulo on head/tail.
- Empty buffer: all write enables 0, debug_wen 0.
- Forwarding: lookup_hit/lookup_data scan valid buffered entries (regwrite, writereg == lookup_id != 0) and return the youngest. Entries draining this cycle still count as hits; the lookup is purely combinational.
- Debug: debug_pc = pcplus4 - 4 of the youngest drained entry, registered; debug_wen pulses 1 cycle after the drain.

Test Plan:
- Single lane, LB at aluout=0x1003, rd=0x80AA_BBCC, writereg=5 -> next cycle rf_wen=1, rf_wid=5, rf_wdata=0xFFFF_FF80; debug_pc = pcplus4-4 one cycle later.
- LANES=2, WPORTS=1, both lanes valid writing r3=1 then r4=2 -> r3 written cycle t+1, r4 at t+2, count 2->1->0.
- WPORTS=2, both lanes write r7 (0x11 older, 0x22 younger) -> only port1 enabled, r7=0x22.
- Fill: LANES=2, DEPTH=8, stream with drain limited to 1/cycle -> in_ready drops when count=7; no entry lost or reordered; pointers wrap past entry 7 correctly.
- MULT result (hi=0x1, lo=0x2) followed by MTLO 0x5 in the same WPORTS=2 window -> MULT drains first with hi_wen=lo_wen=1; MTLO next cycle, lo_wdata=0x5.
- Two entries writing r9 (0xA then 0xB) buffered, lookup_id=9 -> hit=1, data=0xB; resetn pulled low mid-drain -> all enables 0 immediately, count=0, hit=0.
